// File: rtl/snn_adder_scheduler.sv
// Shares one synaptic adder across the tinySNN neurons: issues one neuron per slot,
// integrates the returned sum into that neuron's membrane. Optional leak: SNN_SCHED_LEAK_EN.
module snn_adder_scheduler #(
    parameter int unsigned p_input_width = 16,
    parameter int unsigned p_sum_width   = 22,
    parameter int unsigned p_neurons     = 8,
    parameter int unsigned p_synapses    = 42,
    parameter int unsigned p_adder_lat   = 1,
    parameter int          p_threshold   = 1000,
    parameter int unsigned p_leak_shift  = 3
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_start,
    input  logic                                i_clear,
    input  logic [p_synapses-1:0]               i_spikes,
    output logic                                o_busy,
    output logic [$clog2(p_neurons)-1:0]        o_nidx,
    output logic [p_synapses-1:0]               o_syn_mask,
    output logic                                o_sum_req,
    input  logic signed [p_sum_width-1:0]       i_sum,
    output logic [p_neurons-1:0]                o_fire,
    output logic                                o_done
);
    localparam int unsigned IDX_W = $clog2(p_neurons);
    localparam int unsigned MEM_W = p_sum_width + 2;
    localparam int unsigned SUM_W = MEM_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(p_neurons - 1);
    localparam logic [3:0] CNT_LAST = 4'(p_adder_lat - 2);
    localparam logic signed [MEM_W-1:0] THR = MEM_W'(p_threshold);
    localparam logic signed [MEM_W-1:0] V_MAX = {1'b0, {(MEM_W-1){1'b1}}};
    localparam logic signed [MEM_W-1:0] V_MIN = {1'b1, {(MEM_W-1){1'b0}}};

    if (p_sum_width != p_input_width + 6 || p_leak_shift >= MEM_W ||
        p_neurons < 2 || p_neurons > 16 || p_adder_lat < 1 || p_adder_lat > 15) begin : g_param_check
        $error("snn_adder_scheduler: illegal parameter combination");
    end

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_UPDATE, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [3:0]                cnt_q, cnt_d;
    logic [p_synapses-1:0]     mask_q, mask_d;
    logic [p_neurons-1:0]      fire_q, fire_d;
    logic signed [MEM_W-1:0]   mem_q [p_neurons];
    logic signed [MEM_W-1:0]   mem_d [p_neurons];
    logic                      busy_q, req_q, done_q;
    logic signed [MEM_W-1:0]   v_cur, leak, v_sat;
    logic signed [SUM_W-1:0]   v_sum;

    // Next-state, membrane update and frame bookkeeping
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        fire_d  = fire_q;
        mem_d   = mem_q;
        v_cur   = mem_q[idx_q];
`ifdef SNN_SCHED_LEAK_EN
        leak    = v_cur >>> p_leak_shift;
`else
        leak    = '0;
`endif
        v_sum   = SUM_W'(v_cur) - SUM_W'(leak) + SUM_W'(i_sum);
        // Top two bits disagree only when the 25-bit result left the 24-bit range
        if (v_sum[SUM_W-1] != v_sum[SUM_W-2]) begin
            v_sat = v_sum[SUM_W-1] ? V_MIN : V_MAX;
        end else begin
            v_sat = v_sum[MEM_W-1:0];
        end

        unique case (state_q)
            S_IDLE: begin
                if (i_clear) begin
                    for (int n = 0; n < p_neurons; n++) mem_d[n] = '0;
                end
                if (i_start) begin
                    mask_d  = i_spikes;
                    idx_d   = '0;
                    fire_d  = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = (p_adder_lat == 1) ? S_UPDATE : S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == CNT_LAST) state_d = S_UPDATE;
                else                   cnt_d   = cnt_q + 4'd1;
            end
            S_UPDATE: begin
                if (v_sat >= THR) begin
                    fire_d[idx_q] = 1'b1;
                    mem_d[idx_q]  = '0;
                end else begin
                    mem_d[idx_q]  = v_sat;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            fire_q  <= '0;
            busy_q  <= 1'b0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            for (int n = 0; n < p_neurons; n++) mem_q[n] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            fire_q  <= fire_d;
            busy_q  <= (state_d != S_IDLE);
            req_q   <= (state_d == S_ISSUE);
            done_q  <= (state_d == S_DONE);
            mem_q   <= mem_d;
        end
    end

    assign o_busy     = busy_q;
    assign o_nidx     = idx_q;
    assign o_syn_mask = mask_q;
    assign o_sum_req  = req_q;
    assign o_fire     = fire_q;
    assign o_done     = done_q;
endmodule

// File: tb/tb_snn_adder_scheduler.sv
// Directed bench for snn_adder_scheduler: a latency-1 instance (a) and a latency-3 instance (b).
module tb_snn_adder_scheduler;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                start_a, clear_a, busy_a, req_a, done_a;
    logic [41:0]         spk_a, mask_a;
    logic signed [21:0]  sum_a;
    logic [2:0]          nidx_a;
    logic [7:0]          fire_a;

    logic                start_b, clear_b, busy_b, req_b, done_b;
    logic [41:0]         spk_b, mask_b;
    logic signed [21:0]  sum_b;
    logic [2:0]          nidx_b;
    logic [7:0]          fire_b;

    int checks = 0;
    int errors = 0;
    int dcyc, ndone, npulse, hit;

`ifdef SNN_SCHED_LEAK_EN
    localparam int EXP_POKE_V = 625;
    localparam int EXP_SAT4   = -6942720;
    localparam int EXP_SAT5   = -8172032;
`else
    localparam int EXP_POKE_V = 700;
    localparam int EXP_SAT4   = -8388608;
    localparam int EXP_SAT5   = -8388608;
`endif

    snn_adder_scheduler dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_clear(clear_a), .i_spikes(spk_a),
        .o_busy(busy_a), .o_nidx(nidx_a), .o_syn_mask(mask_a), .o_sum_req(req_a),
        .i_sum(sum_a), .o_fire(fire_a), .o_done(done_a)
    );

    snn_adder_scheduler #(.p_adder_lat(3)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_clear(clear_b), .i_spikes(spk_b),
        .o_busy(busy_b), .o_nidx(nidx_b), .o_syn_mask(mask_b), .o_sum_req(req_b),
        .i_sum(sum_b), .o_fire(fire_b), .o_done(done_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One frame on instance a; poke re-pulses start/clear in cycle 5 and runs 40 cycles
    task automatic frame_a(input logic [41:0] spk, input logic signed [21:0] s, input logic clr,
                           input logic poke, output int done_cyc, output int n_done);
        spk_a = spk; sum_a = s; clear_a = clr; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; clear_a = 1'b0;
        done_cyc = -1; n_done = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) check("a_busy_first", 64'(busy_a), 64'(1));
            if (poke && c == 5) begin start_a = 1'b1; clear_a = 1'b1; end
            if (poke && c == 6) begin start_a = 1'b0; clear_a = 1'b0; end
            if (done_a) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    check("a_busy_at_done", 64'(busy_a), 64'(1));
                end
                if (!poke) break;
            end
        end
        @(posedge clk); #1;
        check("a_busy_after", 64'(busy_a), 64'(0));
    endtask

    // One frame on instance b, checking issue spacing, index order and mask stability
    task automatic frame_b(input logic [41:0] spk, input logic signed [21:0] s,
                           output int done_cyc, output int n_req);
        spk_b = spk; sum_b = s; start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        spk_b = '0;
        done_cyc = -1; n_req = 0;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            check("b_mask_hold", 64'(mask_b), 64'(spk));
            if (req_b) begin
                check("b_req_cycle", 64'(c), 64'(1 + 4 * n_req));
                check("b_req_nidx", 64'(nidx_b), 64'(n_req));
                n_req++;
            end
            if (done_b) begin done_cyc = c; break; end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0; clear_a = 1'b0; spk_a = '0; sum_a = '0;
        start_b = 1'b0; clear_b = 1'b0; spk_b = '0; sum_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy_a), 64'(0));
        check("rst_fire", 64'(fire_a), 64'(0));
        check("rst_req", 64'(req_a), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Sequencing on the latency-3 instance
        frame_b(42'h2AAAAAAAAAA, 22'sd2000, dcyc, npulse);
        check("b_req_count", 64'(npulse), 64'(8));
        check("b_done_cycle", 64'(dcyc), 64'(33));
        check("b_fire", 64'(fire_b), 64'(8'hFF));

        // Integrate frames on the latency-1 instance
        frame_a(42'h3FFFFFFFFFF, 22'sd500, 1'b0, 1'b0, dcyc, ndone);
        check("f1_done_cycle", 64'(dcyc), 64'(17));
        check("f1_fire", 64'(fire_a), 64'(8'h00));
        check("f1_v0", 64'(dut_a.mem_q[0]), 64'(500));
        check("f1_v7", 64'(dut_a.mem_q[7]), 64'(500));
        frame_a(42'h3FFFFFFFFFF, 22'sd600, 1'b0, 1'b0, dcyc, ndone);
        check("f2_fire", 64'(fire_a), 64'(8'hFF));
        check("f2_v3", 64'(dut_a.mem_q[3]), 64'(0));

        // Clear together with start integrates from zero
        frame_a(42'h3FFFFFFFFFF, 22'sd500, 1'b0, 1'b0, dcyc, ndone);
        check("f3_v2", 64'(dut_a.mem_q[2]), 64'(500));
        frame_a(42'h3FFFFFFFFFF, 22'sd600, 1'b1, 1'b0, dcyc, ndone);
        check("clrstart_fire", 64'(fire_a), 64'(8'h00));
        check("clrstart_v5", 64'(dut_a.mem_q[5]), 64'(600));

        // Start and clear while busy are ignored
        frame_a(42'h155, 22'sd100, 1'b0, 1'b1, dcyc, ndone);
        check("poke_done_count", 64'(ndone), 64'(1));
        check("poke_done_cycle", 64'(dcyc), 64'(17));
        check("poke_v0", 64'(dut_a.mem_q[0]), 64'(EXP_POKE_V));
        check("poke_v7", 64'(dut_a.mem_q[7]), 64'(EXP_POKE_V));
        check("poke_mask", 64'(mask_a), 64'(42'h155));

        // Three-cycle reset with state held in both instances
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("mrst_busy", 64'(busy_a), 64'(0));
        check("mrst_req", 64'(req_a), 64'(0));
        check("mrst_done", 64'(done_a), 64'(0));
        check("mrst_mask_a", 64'(mask_a), 64'(0));
        check("mrst_v0", 64'(dut_a.mem_q[0]), 64'(0));
        check("mrst_v6", 64'(dut_a.mem_q[6]), 64'(0));
        check("mrst_fire_b", 64'(fire_b), 64'(0));
        check("mrst_nidx_b", 64'(nidx_b), 64'(0));
        check("mrst_mask_b", 64'(mask_b), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Saturation at the negative rail
        clear_a = 1'b1;
        @(posedge clk); #1;
        clear_a = 1'b0;
        for (int f = 1; f <= 5; f++) begin
            frame_a(42'h3FFFFFFFFFF, 22'h200000, 1'b0, 1'b0, dcyc, ndone);
            if (f == 4) check("sat4_v0", 64'(dut_a.mem_q[0]), 64'(EXP_SAT4));
        end
        check("sat5_v0", 64'(dut_a.mem_q[0]), 64'(EXP_SAT5));
        check("sat5_v7", 64'(dut_a.mem_q[7]), 64'(EXP_SAT5));
        check("sat5_fire", 64'(fire_a), 64'(8'h00));

        // Reset during WAIT of neuron 3 on instance b
        spk_b = 42'h3FFFFFFFFFF; sum_b = 22'sd2000; start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        hit = 0;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (req_b && nidx_b == 3'd3) begin hit = 1; break; end
        end
        check("b_reach_n3", 64'(hit), 64'(1));
        @(negedge clk);
        check("b_fire_partial", 64'(fire_b), 64'(8'h07));
        rst = 1'b1;
        #1;
        check("b_abort_busy", 64'(busy_b), 64'(0));
        check("b_abort_fire", 64'(fire_b), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        frame_b(42'h3FFFFFFFFFF, 22'sd2000, dcyc, npulse);
        check("b_after_done", 64'(dcyc), 64'(33));
        check("b_after_fire", 64'(fire_b), 64'(8'hFF));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
